// File: rtl/knn_ref_buffer.sv
// knn_ref_buffer: holds NUM_REFS reference points and replays them per streamed dimension; define KNN_REFBUF_ABSDIFF_EN to add per-lane |data-ref| outputs
module knn_ref_buffer #(
  parameter int NUM_DIMENSIONS = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REFS = 4,
  localparam int DIM_W = $clog2(NUM_DIMENSIONS),
  localparam int REF_W = NUM_REFS > 1 ? $clog2(NUM_REFS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [NUM_REFS*DATA_WIDTH-1:0] out_ref,
  output logic [DIM_W-1:0]               out_dim,
  output logic                           out_last,
`ifdef KNN_REFBUF_ABSDIFF_EN
  output logic [NUM_REFS*DATA_WIDTH-1:0] out_absdiff,
`endif
  output logic                           refs_loaded
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, STREAM = 2'd2;
  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(NUM_DIMENSIONS - 1);
  logic [1:0] state;
  logic [DIM_W-1:0] load_dim, stream_dim;
  logic [REF_W-1:0] load_ref;
  logic [DATA_WIDTH-1:0] mem [NUM_REFS][NUM_DIMENSIONS];
  logic reload, accept, dim_end, load_end;
  always_comb begin
    reload = state == STREAM && start && stream_dim == '0;
    in_ready = state == LOAD || (state == STREAM && !reload && (!out_valid || out_ready));
    accept = in_valid && in_ready;
    dim_end = load_dim == DIM_LAST;
    load_end = dim_end && load_ref == REF_W'(NUM_REFS - 1);
  end
  always_ff @(posedge clk)
    if (state == LOAD && accept) mem[load_ref][load_dim] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      load_dim <= '0;
      load_ref <= '0;
      stream_dim <= '0;
      refs_loaded <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ref <= '0;
      out_dim <= '0;
      out_last <= 1'b0;
`ifdef KNN_REFBUF_ABSDIFF_EN
      out_absdiff <= '0;
`endif
    end else begin
      if (state == STREAM && accept) begin
        out_valid <= 1'b1;
        out_data <= in_data;
        out_dim <= stream_dim;
        out_last <= stream_dim == DIM_LAST;
        for (int r = 0; r < NUM_REFS; r++) begin
          out_ref[r*DATA_WIDTH +: DATA_WIDTH] <= mem[r][stream_dim];
`ifdef KNN_REFBUF_ABSDIFF_EN
          out_absdiff[r*DATA_WIDTH +: DATA_WIDTH] <= in_data > mem[r][stream_dim] ?
            in_data - mem[r][stream_dim] : mem[r][stream_dim] - in_data;
`endif
        end
        stream_dim <= stream_dim == DIM_LAST ? '0 : stream_dim + DIM_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if ((state == IDLE && start) || reload) begin
        state <= LOAD;
        load_dim <= '0;
        load_ref <= '0;
        refs_loaded <= 1'b0;
      end else if (state == LOAD && accept) begin
        load_dim <= dim_end ? '0 : load_dim + DIM_W'(1);
        load_ref <= dim_end ? load_ref + REF_W'(1) : load_ref;
        if (load_end) begin
          state <= STREAM;
          refs_loaded <= 1'b1;
          stream_dim <= '0;
        end
      end
    end
  end
endmodule
